cam_capture_packer: RTL and testbench
=====================================

CAM_CAPTURE_PACKER -- requirements
Module: cam_capture_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, camera bus width in bits.
REQ-002 SHALL have parameter BYTES_PER_PIX, default 2, bus beats per pixel (1..4).
REQ-003 SHALL have parameter CNT_W, default 12, width of pixel and line counters.
REQ-004 SHALL have port cam_pclk, input, 1, sole clock.
REQ-005 SHALL have port system_rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports cam_vsync / cam_href, input, 1 each, camera sync in the cam_pclk domain (vsync high = blanking).
REQ-007 SHALL have port cam_data, input, DATA_W, camera bus.
REQ-008 SHALL have port cfg_en, input, 1, capture enable.
REQ-009 SHALL have port cfg_decim, input, 2, decimation 2^cfg_decim on both axes (0 = 1:1, 3 = 1:8).
REQ-010 SHALL have port cfg_swap, input, 1, 1 = first beat in LSBs.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1, out_data output BYTES_PER_PIX*DATA_W, out_sof output 1, out_eol output 1 (stream).
REQ-012 SHALL have ports stat_ovf output 1 (sticky drop), stat_partial output 1 (sticky partial pixel), stat_frames output 16, stat_lines output CNT_W, stat_width output CNT_W.

Function
REQ-013 SHALL register cam_vsync, cam_href and cam_data once (stage S0); all decisions use S0 values.
REQ-014 SHALL run FSM IDLE -> WAIT_FRAME (cfg_en=1) -> ACTIVE (S0 vsync falling edge) -> WAIT_FRAME on S0 vsync rising edge if cfg_en=1, else IDLE.
REQ-015 SHALL sample cfg_decim and cfg_swap only on WAIT_FRAME->ACTIVE; cfg_en deasserted in ACTIVE lets the frame finish.
REQ-016 SHALL reset the beat counter on S0 href rising edge, count beats while S0 href=1, and assemble a pixel when the count reaches BYTES_PER_PIX-1; first beat in MSBs unless swap.
REQ-017 SHALL keep a pixel when (pixel index mod 2^d)==0 and (line index mod 2^d)==0; indices restart at 0 per line/frame.
REQ-018 SHALL hold each kept pixel in a one-entry hold register; it is emitted with out_eol=0 when the next kept pixel in that line completes, or with out_eol=1 on S0 href falling edge.
REQ-019 SHALL emit out_data/out_eol/out_sof in the cycle after the triggering event; out_sof=1 only on the first emitted pixel of a frame.
REQ-020 SHALL hold out_valid and payload stable until out_valid&out_ready; out_valid falls the cycle after acceptance unless a new emission occurs.
REQ-021 SHALL, when an emission arrives while out_valid=1 and out_ready=0, drop the new pixel, keep the stalled one, set stat_ovf; an eol-marked drop sets out_eol on the stalled pixel.
REQ-022 SHALL discard an incomplete pixel at href fall (beat count nonzero) and set stat_partial.
REQ-023 SHALL, on S0 vsync rising edge in ACTIVE with hold register full, emit it with out_eol=1.
REQ-024 SHALL at frame end update stat_lines (raw href lines), increment stat_frames (wraps 0xFFFF->0); stat_width = raw pixels of last line, updated each href fall.
REQ-025 SHALL saturate pixel and line counters at 2^CNT_W-1.
REQ-026 SHALL clear stat_ovf and stat_partial on WAIT_FRAME->ACTIVE.

Reset
REQ-027 SHALL on system_rstn=0 asynchronously set FSM IDLE, out_valid=0, out_data=0, out_sof=0, out_eol=0, all stats and counters 0, hold register empty.
REQ-028 SHALL, after reset released mid-frame, capture nothing until the next vsync falling edge.

Structure
REQ-029 SHALL place FSM state enum and decimation encoding constants in shared package cam_pkg.
REQ-030 SHALL implement beat assembly (REQ-016, REQ-022) in sub-module cam_pix_assembler.

Verification
REQ-031 Defaults, 4-pixel line 0x11,0x22,0x33,0x44,..., out_ready=1 -> 4 beats 0x1122,0x3344,0x5566,0x7788; first sof=1, last eol=1.
REQ-032 cfg_decim=1, 4 lines x 8 pixels -> 8 emissions (lines 0,2; pixels 0,2,4,6), eol on pixel 6, stat_lines=4, stat_width=8.
REQ-033 out_ready=0 for whole 3-pixel line -> only pixel 0 held, out_eol=1, stat_ovf=1; cleared at next frame start.
REQ-034 Line of 5 beats, BYTES_PER_PIX=2 -> 2 pixels, second eol=1, stat_partial=1.
REQ-035 Reset pulsed mid-line -> outputs 0 same cycle; no out_valid until after next vsync fall; stat_frames=0.
REQ-036 cfg_swap=1, beats 0xAB,0xCD -> out_data=0xCDAB; cfg_en dropped mid-frame -> frame completes, FSM IDLE, stat_frames +1.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared capture FSM states, beat-counter width and decimation encodings with their index masks
package cam_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} cap_state_e;
  localparam int BEAT_W = 2;
  localparam logic [1:0] DECIM_1 = 2'd0;
  localparam logic [1:0] DECIM_2 = 2'd1;
  localparam logic [1:0] DECIM_4 = 2'd2;
  localparam logic [1:0] DECIM_8 = 2'd3;
  function automatic logic [2:0] decim_mask(input logic [1:0] d);
    return d == DECIM_8 ? 3'b111 : d == DECIM_4 ? 3'b011 : d == DECIM_2 ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/cam_pix_assembler.sv
// cam_pix_assembler: packs S0 bus beats into pixels (hr_i/hr_rise_i/hr_fall_i/dat_i/swap_i in; pix_vld_o pulse, pix_o, partial_o pulse out)
module cam_pix_assembler import cam_pkg::*; #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2
) (
  input  logic                            cam_pclk,
  input  logic                            system_rstn,
  input  logic                            hr_i,
  input  logic                            hr_rise_i,
  input  logic                            hr_fall_i,
  input  logic                            swap_i,
  input  logic [DATA_W-1:0]               dat_i,
  output logic                            pix_vld_o,
  output logic [BYTES_PER_PIX*DATA_W-1:0] pix_o,
  output logic                            partial_o
);
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BYTES_PER_PIX - 1);
  logic [BEAT_W-1:0] cnt_q, cnt_d, idx;
  logic [DATA_W-1:0] beats_q [BYTES_PER_PIX];
  assign idx       = hr_rise_i ? '0 : cnt_q;
  assign pix_vld_o = hr_i && idx == LAST;
  assign partial_o = hr_fall_i && cnt_q != '0;
  assign cnt_d     = (!hr_i || pix_vld_o) ? '0 : idx + 1'b1;
  always_comb begin
    pix_o = '0;
    for (int i = 0; i < BYTES_PER_PIX; i++)
      pix_o[(swap_i ? i : BYTES_PER_PIX - 1 - i)*DATA_W +: DATA_W] = BEAT_W'(i) == idx ? dat_i : beats_q[i];
  end
  always_ff @(posedge cam_pclk or negedge system_rstn) begin
    if (!system_rstn) begin
      cnt_q <= '0;
      for (int i = 0; i < BYTES_PER_PIX; i++) beats_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < BYTES_PER_PIX; i++)
        if (hr_i && BEAT_W'(i) == idx) beats_q[i] <= dat_i;
    end
  end
endmodule

// File: rtl/cam_capture_packer.sv
// cam_capture_packer: camera DVP capture to decimated pixel stream (cam_* sync/data in, cfg_* controls, out_* valid/ready stream, stat_* counters)
module cam_capture_packer import cam_pkg::*; #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int CNT_W         = 12
) (
  input  logic                            cam_pclk,
  input  logic                            system_rstn,
  input  logic                            cam_vsync,
  input  logic                            cam_href,
  input  logic [DATA_W-1:0]               cam_data,
  input  logic                            cfg_en,
  input  logic [1:0]                      cfg_decim,
  input  logic                            cfg_swap,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BYTES_PER_PIX*DATA_W-1:0] out_data,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic                            stat_ovf,
  output logic                            stat_partial,
  output logic [15:0]                     stat_frames,
  output logic [CNT_W-1:0]                stat_lines,
  output logic [CNT_W-1:0]                stat_width
);
  localparam int PIX_W = BYTES_PER_PIX * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  cap_state_e state_q, state_d;
  logic vs_q, hr_q, vs_p_q, hr_p_q;
  logic [DATA_W-1:0] dat_q;
  logic vs_rise, vs_fall, hr_rise, hr_fall;
  logic [1:0] decim_q;
  logic swap_q;
  logic [CNT_W-1:0] px_q, px_d, ln_q, ln_d, mask;
  logic hold_v_q, hold_v_d;
  logic [PIX_W-1:0] hold_q, hold_d;
  logic sof_pend_q, sof_pend_d;
  logic out_valid_q, out_valid_d, out_eol_q, out_eol_d, out_sof_q, out_sof_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;
  logic ovf_q, ovf_d, part_q, part_d;
  logic [15:0] frames_q, frames_d;
  logic [CNT_W-1:0] lines_q, lines_d, width_q, width_d;
  logic asm_vld, asm_part;
  logic [PIX_W-1:0] asm_pix;
  logic start, active, fend, line_end, done, kept, em, em_eol, load, drop;
  assign vs_rise = !vs_p_q && vs_q;
  assign vs_fall = vs_p_q && !vs_q;
  assign hr_rise = !hr_p_q && hr_q;
  assign hr_fall = hr_p_q && !hr_q;
  cam_pix_assembler #(.DATA_W(DATA_W), .BYTES_PER_PIX(BYTES_PER_PIX)) u_asm (
    .cam_pclk   (cam_pclk),
    .system_rstn(system_rstn),
    .hr_i       (hr_q),
    .hr_rise_i  (hr_rise),
    .hr_fall_i  (hr_fall),
    .swap_i     (swap_q),
    .dat_i      (dat_q),
    .pix_vld_o  (asm_vld),
    .pix_o      (asm_pix),
    .partial_o  (asm_part)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = cfg_en ? WAIT_FRAME : IDLE;
      WAIT_FRAME: state_d = !cfg_en ? IDLE : vs_fall ? ACTIVE : WAIT_FRAME;
      default:    state_d = !vs_rise ? ACTIVE : cfg_en ? WAIT_FRAME : IDLE;
    endcase
  end
  always_comb begin
    start    = state_q == WAIT_FRAME && cfg_en && vs_fall;
    active   = state_q == ACTIVE;
    fend     = active && vs_rise;
    line_end = active && hr_fall;
    done     = active && asm_vld;
    mask     = CNT_W'(decim_mask(decim_q));
    kept     = done && (px_q & mask) == '0 && (ln_q & mask) == '0;
    // The held pixel leaves when its successor arrives (mid-line) or the line/frame closes (eol).
    em       = hold_v_q && (kept || line_end || fend);
    em_eol   = !kept;
    load     = em && (!out_valid_q || out_ready);
    drop     = em && !load;
    px_d     = (start || line_end) ? '0 : (done && px_q != CNT_MAX) ? px_q + 1'b1 : px_q;
    ln_d     = start ? '0 : (line_end && ln_q != CNT_MAX) ? ln_q + 1'b1 : ln_q;
    hold_v_d = kept ? 1'b1 : (line_end || fend || start) ? 1'b0 : hold_v_q;
    hold_d   = kept ? asm_pix : hold_q;
    sof_pend_d  = start ? 1'b1 : load ? 1'b0 : sof_pend_q;
    out_valid_d = load ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
    out_data_d  = load ? hold_q : out_data_q;
    out_sof_d   = load ? sof_pend_q : out_sof_q;
    // A dropped end-of-line pixel still marks the line end on the stalled one.
    out_eol_d   = load ? em_eol : (drop && em_eol) ? 1'b1 : out_eol_q;
    ovf_d    = start ? 1'b0 : drop ? 1'b1 : ovf_q;
    part_d   = start ? 1'b0 : (active && asm_part) ? 1'b1 : part_q;
    frames_d = fend ? frames_q + 16'd1 : frames_q;
    lines_d  = fend ? ln_q : lines_q;
    width_d  = line_end ? px_q : width_q;
  end
  always_ff @(posedge cam_pclk or negedge system_rstn) begin
    if (!system_rstn) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      hr_q        <= 1'b0;
      vs_p_q      <= 1'b0;
      hr_p_q      <= 1'b0;
      dat_q       <= '0;
      decim_q     <= DECIM_1;
      swap_q      <= 1'b0;
      px_q        <= '0;
      ln_q        <= '0;
      hold_v_q    <= 1'b0;
      hold_q      <= '0;
      sof_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      ovf_q       <= 1'b0;
      part_q      <= 1'b0;
      frames_q    <= '0;
      lines_q     <= '0;
      width_q     <= '0;
    end else begin
      state_q     <= state_d;
      vs_q        <= cam_vsync;
      hr_q        <= cam_href;
      vs_p_q      <= vs_q;
      hr_p_q      <= hr_q;
      dat_q       <= cam_data;
      decim_q     <= start ? cfg_decim : decim_q;
      swap_q      <= start ? cfg_swap : swap_q;
      px_q        <= px_d;
      ln_q        <= ln_d;
      hold_v_q    <= hold_v_d;
      hold_q      <= hold_d;
      sof_pend_q  <= sof_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      ovf_q       <= ovf_d;
      part_q      <= part_d;
      frames_q    <= frames_d;
      lines_q     <= lines_d;
      width_q     <= width_d;
    end
  end
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sof      = out_sof_q;
  assign out_eol      = out_eol_q;
  assign stat_ovf     = ovf_q;
  assign stat_partial = part_q;
  assign stat_frames  = frames_q;
  assign stat_lines   = lines_q;
  assign stat_width   = width_q;
endmodule

// File: tb/tb_cam_capture_packer.sv
// tb_cam_capture_packer: directed checks of capture, decimation, stall drop, partial pixels, swap, cfg_en drop and reset
module tb_cam_capture_packer;
  import cam_pkg::*;
  logic cam_pclk = 0, system_rstn = 0;
  logic cam_vsync = 1, cam_href = 0;
  logic [7:0] cam_data = 0;
  logic cfg_en = 0, cfg_swap = 0, out_ready = 1;
  logic [1:0] cfg_decim = 0;
  logic out_valid, out_sof, out_eol, stat_ovf, stat_partial;
  logic [15:0] out_data, stat_frames;
  logic [11:0] stat_lines, stat_width;
  int vecs = 0, errs = 0;
  logic [15:0] q_d[$];
  logic q_s[$], q_e[$];
  cam_capture_packer dut (
    .cam_pclk(cam_pclk), .system_rstn(system_rstn), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cfg_en(cfg_en), .cfg_decim(cfg_decim), .cfg_swap(cfg_swap),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
    .out_eol(out_eol), .stat_ovf(stat_ovf), .stat_partial(stat_partial), .stat_frames(stat_frames),
    .stat_lines(stat_lines), .stat_width(stat_width)
  );
  always #5 cam_pclk = ~cam_pclk;
  always @(negedge cam_pclk)
    if (out_valid && out_ready) begin
      q_d.push_back(out_data);
      q_s.push_back(out_sof);
      q_e.push_back(out_eol);
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge cam_pclk);
    #1;
    cam_vsync = vs;
    cam_href = hr;
    cam_data = d;
  endtask
  task automatic idle(input int n, input logic vs);
    repeat (n) cyc(vs, 1'b0, 8'h00);
  endtask
  task automatic frame_start;
    idle(3, 1'b1);
    idle(4, 1'b0);
  endtask
  task automatic line(input int beats);
    for (int i = 0; i < beats; i++) cyc(1'b0, 1'b1, 8'((i + 1) * 17));
    idle(4, 1'b0);
  endtask
  task automatic frame_end;
    idle(6, 1'b1);
  endtask
  task automatic clr;
    q_d.delete();
    q_s.delete();
    q_e.delete();
  endtask
  initial begin
    repeat (3) @(posedge cam_pclk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_frames", 32'(stat_frames), 0);
    chk("rst_width", 32'(stat_width), 0);
    system_rstn = 1;
    cfg_en = 1;
    // plain 4-pixel line
    frame_start;
    line(8);
    frame_end;
    chk("f1_count", q_d.size(), 4);
    chk("f1_d0", 32'(q_d[0]), 32'h1122);
    chk("f1_d1", 32'(q_d[1]), 32'h3344);
    chk("f1_d2", 32'(q_d[2]), 32'h5566);
    chk("f1_d3", 32'(q_d[3]), 32'h7788);
    chk("f1_sof0", 32'(q_s[0]), 1);
    chk("f1_sof1", 32'(q_s[1]), 0);
    chk("f1_eol0", 32'(q_e[0]), 0);
    chk("f1_eol3", 32'(q_e[3]), 1);
    chk("f1_frames", 32'(stat_frames), 1);
    chk("f1_lines", 32'(stat_lines), 1);
    chk("f1_width", 32'(stat_width), 4);
    clr;
    // 1:2 decimation, 4 lines of 8 pixels
    cfg_decim = 2'd1;
    frame_start;
    repeat (4) line(16);
    frame_end;
    chk("f2_count", q_d.size(), 8);
    chk("f2_d0", 32'(q_d[0]), 32'h1122);
    chk("f2_sof0", 32'(q_s[0]), 1);
    chk("f2_d1", 32'(q_d[1]), 32'h5566);
    chk("f2_eol1", 32'(q_e[1]), 0);
    chk("f2_d3", 32'(q_d[3]), 32'hDDEE);
    chk("f2_eol3", 32'(q_e[3]), 1);
    chk("f2_d4", 32'(q_d[4]), 32'h1122);
    chk("f2_sof4", 32'(q_s[4]), 0);
    chk("f2_d7", 32'(q_d[7]), 32'hDDEE);
    chk("f2_eol7", 32'(q_e[7]), 1);
    chk("f2_lines", 32'(stat_lines), 4);
    chk("f2_width", 32'(stat_width), 8);
    chk("f2_frames", 32'(stat_frames), 2);
    clr;
    // stalled sink for a whole 3-pixel line
    cfg_decim = 2'd0;
    frame_start;
    out_ready = 0;
    line(6);
    chk("f3_valid", 32'(out_valid), 1);
    chk("f3_data", 32'(out_data), 32'h1122);
    chk("f3_eol", 32'(out_eol), 1);
    chk("f3_sof", 32'(out_sof), 1);
    chk("f3_ovf", 32'(stat_ovf), 1);
    out_ready = 1;
    idle(3, 1'b0);
    chk("f3_drain", q_d.size(), 1);
    frame_end;
    clr;
    // next frame clears ovf; 5-beat line leaves a partial pixel
    frame_start;
    chk("f4_ovf_clr", 32'(stat_ovf), 0);
    line(5);
    frame_end;
    chk("f4_count", q_d.size(), 2);
    chk("f4_d0", 32'(q_d[0]), 32'h1122);
    chk("f4_eol0", 32'(q_e[0]), 0);
    chk("f4_d1", 32'(q_d[1]), 32'h3344);
    chk("f4_eol1", 32'(q_e[1]), 1);
    chk("f4_partial", 32'(stat_partial), 1);
    chk("f4_width", 32'(stat_width), 2);
    clr;
    // swapped beats, enable dropped mid-frame
    cfg_swap = 1;
    frame_start;
    cfg_en = 0;
    cyc(1'b0, 1'b1, 8'hAB);
    cyc(1'b0, 1'b1, 8'hCD);
    idle(4, 1'b0);
    frame_end;
    chk("f5_count", q_d.size(), 1);
    chk("f5_data", 32'(q_d[0]), 32'hCDAB);
    chk("f5_eol", 32'(q_e[0]), 1);
    chk("f5_partial_clr", 32'(stat_partial), 0);
    chk("f5_frames", 32'(stat_frames), 5);
    chk("f5_idle", 32'(dut.state_q), 32'(IDLE));
    clr;
    cfg_swap = 0;
    frame_start;
    line(8);
    frame_end;
    chk("f6_ignored", q_d.size(), 0);
    chk("f6_frames", 32'(stat_frames), 5);
    // reset pulsed mid-line
    cfg_en = 1;
    frame_start;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'((i + 1) * 17));
    @(posedge cam_pclk);
    #1;
    system_rstn = 0;
    #2;
    chk("r_valid", 32'(out_valid), 0);
    chk("r_data", 32'(out_data), 0);
    chk("r_sof", 32'(out_sof), 0);
    chk("r_frames", 32'(stat_frames), 0);
    @(posedge cam_pclk);
    #1;
    system_rstn = 1;
    line(5);
    frame_end;
    chk("r_no_out", q_d.size(), 0);
    chk("r_frames2", 32'(stat_frames), 0);
    frame_start;
    line(8);
    frame_end;
    chk("r_count", q_d.size(), 4);
    chk("r_d0", 32'(q_d[0]), 32'h1122);
    chk("r_sof0", 32'(q_s[0]), 1);
    chk("r_frames3", 32'(stat_frames), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
